// File: rtl/square_writer_pkg.sv
// Shared screen geometry and FSM state type for the square writer and its
// region-test companions.
package square_writer_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SQUARE_SIZE = 24;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned OFF_W       = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } sw_state_t;

endpackage

// File: rtl/square_writer_xy_to_linear.sv
// Maps pixel (x, y) to a linear frame-buffer address y*640+x using
// shift-and-add only; the inverse of linear_to_xy.
module xy_to_linear
  import square_writer_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] y_w;
  logic [ADDR_W-1:0] x_w;

  assign y_w  = ADDR_W'(y);
  assign x_w  = ADDR_W'(x);
  assign addr = (y_w << 9) + (y_w << 7) + x_w;

endmodule

// File: rtl/square_writer.sv
// Draws a 24x24 square into a linear frame buffer, one pixel per completed
// write handshake, clipping pixels that fall off the 640x480 screen.
module square_writer
  import square_writer_pkg::*;
(
  input  logic                m_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  input_x,
  input  logic [COORD_W-1:0]  input_y,
  input  logic                wr_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   full_address,
  output logic                busy,
  output logic                done
);

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SQUARE_SIZE - 1);

  sw_state_t          state, state_nxt;
  logic [COORD_W-1:0] base_x, base_y;
  logic [OFF_W-1:0]   off_x, off_y;

  logic               pix_done;
  logic               last_pix;
  logic [OFF_W-1:0]   step_x, step_y;
  logic [COORD_W-1:0] sel_bx, sel_by;
  logic [OFF_W-1:0]   sel_ox, sel_oy;
  logic [COORD_W:0]   sum_x, sum_y;
  logic               on_screen;
  logic [ADDR_W-1:0]  addr_nxt;

  assign pix_done = (state == RUN) && (!wr_en || wr_ready);
  assign last_pix = (off_x == OFF_LAST) && (off_y == OFF_LAST);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

  // The pixel being prepared is the first one when idle, else the successor
  // of the current one; it is registered so address and wr_en stay aligned.
  always_comb begin
    step_x = off_x + OFF_W'(1);
    step_y = off_y;
    if (off_x == OFF_LAST) begin
      step_x = '0;
      step_y = off_y + OFF_W'(1);
    end
    sel_bx = (state == IDLE) ? input_x : base_x;
    sel_by = (state == IDLE) ? input_y : base_y;
    sel_ox = (state == IDLE) ? '0 : step_x;
    sel_oy = (state == IDLE) ? '0 : step_y;
    sum_x  = {1'b0, sel_bx} + (COORD_W+1)'(sel_ox);
    sum_y  = {1'b0, sel_by} + (COORD_W+1)'(sel_oy);
    on_screen = (sum_x < (COORD_W+1)'(SCREEN_W)) && (sum_y < (COORD_W+1)'(SCREEN_H));
  end

  xy_to_linear u_xy_to_linear (
    .x    (sum_x[COORD_W-1:0]),
    .y    (sum_y[COORD_W-1:0]),
    .addr (addr_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pix_done && last_pix) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      base_x       <= '0;
      base_y       <= '0;
      off_x        <= '0;
      off_y        <= '0;
      wr_en        <= 1'b0;
      full_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_x       <= input_x;
            base_y       <= input_y;
            off_x        <= '0;
            off_y        <= '0;
            wr_en        <= on_screen;
            full_address <= addr_nxt;
          end
        end
        RUN: begin
          if (pix_done) begin
            if (last_pix) begin
              wr_en <= 1'b0;
            end else begin
              off_x        <= step_x;
              off_y        <= step_y;
              wr_en        <= on_screen;
              full_address <= addr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_writer.sv
// Self-checking bench for square_writer: a loop-based pixel model of the
// clipped square is compared against the observed write stream and timing.
module tb_square_writer;

  logic        m_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  input_x = '0;
  logic [9:0]  input_y = '0;
  logic        wr_ready = 1'b0;
  logic        wr_en;
  logic [18:0] full_address;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  square_writer dut (
    .m_clk        (m_clk),
    .reset        (reset),
    .start        (start),
    .input_x      (input_x),
    .input_y      (input_y),
    .wr_ready     (wr_ready),
    .wr_en        (wr_en),
    .full_address (full_address),
    .busy         (busy),
    .done         (done)
  );

  always #5 m_clk = ~m_clk;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int done_cyc, stalls, stable_err, busy_err, post_err;

  function automatic void build_model(input int bx, input int by);
    exp_q.delete();
    for (int dy = 0; dy < 24; dy++)
      for (int dx = 0; dx < 24; dx++)
        if (bx + dx < 640 && by + dy < 480)
          exp_q.push_back(19'((by + dy) * 640 + (bx + dx)));
  endfunction

  // mode 0: ready high, 1: 3-cycle stall on every 24th write, 2: random ready
  task automatic draw(input int bx, input int by, input int mode, input int restart_at);
    int cyc = 1;
    int stall_left = 0;
    bit held = 0;
    logic [18:0] held_addr = '0;
    obs_q.delete();
    done_cyc = -1; stalls = 0; stable_err = 0; busy_err = 0; post_err = 0;
    @(posedge m_clk); #1;
    input_x = 10'(bx); input_y = 10'(by); start = 1'b1; wr_ready = 1'b1;
    while (cyc < 3000) begin
      @(posedge m_clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1;
        input_x = 10'((bx + 37) % 600);
        input_y = 10'((by + 91) % 450);
      end
      if (!busy) busy_err++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (held && (!wr_en || full_address !== held_addr)) stable_err++;
      if (wr_en && !held && mode == 1 && (obs_q.size() % 24) == 0) stall_left = 3;
      case (mode)
        1:       wr_ready = (stall_left == 0);
        2:       wr_ready = ($urandom_range(0, 2) != 0);
        default: wr_ready = 1'b1;
      endcase
      if (stall_left > 0 && wr_en) stall_left--;
      if (wr_en && wr_ready) begin
        obs_q.push_back(full_address);
        held = 0;
      end else if (wr_en) begin
        stalls++;
        held = 1;
        held_addr = full_address;
      end else begin
        held = 0;
      end
    end
    start = 1'b0;
    wr_ready = 1'b1;
    @(posedge m_clk); #1;
    if (busy || done || wr_en) post_err++;
  endtask

  task automatic compare_stream(input string name);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s addr_order: %0d mismatched addresses, expected 0", name, bad);
      end
    end
  endtask

  task automatic compare_timing(input string name, input int exp_done);
    n_checks++;
    if (done_cyc !== exp_done) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    n_checks++;
    if (busy_err != 0 || post_err != 0) begin
      n_fail++;
      $display("FAIL %s busy_window: got %0d/%0d bad cycles expected 0/0", name, busy_err, post_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; input_x = 10'd5; input_y = 10'd5;
    repeat (3) @(posedge m_clk);
    #1;
    n_checks++;
    if ({wr_en, busy, done, full_address} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr_en=%b busy=%b done=%b addr=%0d expected all 0",
               wr_en, busy, done, full_address);
    end
    reset = 1'b0; start = 1'b0;
    @(posedge m_clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_normal();
    build_model(100, 50);
    draw(100, 50, 0, 0);
    compare_stream("normal");
    compare_timing("normal", 578);
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 19'd32100 || obs_q[obs_q.size()-1] !== 19'd46843) begin
      n_fail++;
      $display("FAIL normal_first_last: got %0d/%0d expected 32100/46843",
               obs_q.size() ? obs_q[0] : 0, obs_q.size() ? obs_q[obs_q.size()-1] : 0);
    end
  endtask

  task automatic test_clipping();
    build_model(630, 470);
    draw(630, 470, 2, 0);
    compare_stream("clip");
    compare_timing("clip", 578 + stalls);
    n_checks++;
    if (obs_q.size() != 100 || obs_q[0] !== 19'd301430 || obs_q[99] !== 19'd307199) begin
      n_fail++;
      $display("FAIL clip_first_last: got count %0d expected 100 with 301430..307199", obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    build_model(0, 0);
    draw(0, 0, 1, 0);
    compare_stream("bp");
    compare_timing("bp", 578 + 72);
    n_checks++;
    if (stalls != 72 || stable_err != 0) begin
      n_fail++;
      $display("FAIL bp_stall_hold: got stalls=%0d unstable=%0d expected 72/0", stalls, stable_err);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int bx = $urandom_range(0, 639);
      int by = $urandom_range(0, 479);
      build_model(bx, by);
      draw(bx, by, 2, 0);
      compare_stream("random");
      compare_timing("random", 578 + stalls);
      n_checks++;
      if (stable_err != 0) begin
        n_fail++;
        $display("FAIL random_hold: got %0d unstable stall cycles expected 0", stable_err);
      end
    end
  endtask

  task automatic test_restart();
    build_model(200, 300);
    draw(200, 300, 0, 150);
    compare_stream("restart");
    compare_timing("restart", 578);
  endtask

  task automatic test_scoreboard();
    int bad = 0;
    build_model(317, 222);
    draw(317, 222, 2, 0);
    foreach (obs_q[i]) begin
      int ax = int'(obs_q[i]) % 640;
      int ay = int'(obs_q[i]) / 640;
      if (ax < 317 || ax > 340 || ay < 222 || ay > 245) bad++;
    end
    n_checks++;
    if (bad != 0 || obs_q.size() != 576) begin
      n_fail++;
      $display("FAIL scoreboard_region: got %0d out-of-square of %0d writes expected 0 of 576",
               bad, obs_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int writes = 0;
    int late = 0;
    int cyc = 0;
    @(posedge m_clk); #1;
    input_x = 10'd10; input_y = 10'd10; start = 1'b1; wr_ready = 1'b1;
    @(posedge m_clk); #1;
    start = 1'b0;
    while (writes < 200 && cyc < 1000) begin
      if (wr_en && wr_ready) writes++;
      @(posedge m_clk); #1;
      cyc++;
    end
    n_checks++;
    if (!(wr_en && busy)) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got wr_en=%b busy=%b expected 1/1 at pixel 200", wr_en, busy);
    end
    reset = 1'b1;
    @(posedge m_clk); #1;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got busy=%b wr_en=%b done=%b expected 0/0/0", busy, wr_en, done);
    end
    repeat (700) begin
      @(posedge m_clk); #1;
      if (wr_en || done || busy) late++;
    end
    n_checks++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got %0d active cycles after reset expected 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_clipping();
    test_backpressure();
    test_random();
    test_restart();
    test_scoreboard();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
